// File: rtl/rise_seq_detector.sv
// Rise-edge sequence detector: counts consecutive accepted rises of start and pulses done after
// NUM_RISES of them, or timeout when the inter-rise gap limit expires while armed.
module rise_seq_detector #(
  parameter int unsigned NUM_RISES = 3,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned MAX_GAP   = 16,
  parameter int unsigned GAP_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             start,
  output logic             rise_pulse,
  output logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [15:0]      seq_total
);

  localparam logic IDLE  = 1'b0;
  localparam logic ARMED = 1'b1;

  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(NUM_RISES - 1);
  localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(MAX_GAP - 1);
  localparam logic [GAP_W-1:0] GAP_SAT   = {GAP_W{1'b1}};
  localparam bit               GAP_ON    = (MAX_GAP != 0);

  logic             start_q;
  logic             state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             rise_q;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;
  logic [15:0]      total_q, total_d;

  logic rise;
  logic accept;

  assign rise   = start & ~start_q;
  assign accept = rise & en & ~clr;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    gap_d     = gap_q;
    done_d    = 1'b0;
    timeout_d = 1'b0;
    total_d   = total_q;
    case (state_q)
      IDLE: begin
        count_d = '0;
        if (accept) begin
          state_d = ARMED;
          count_d = CNT_W'(1);
          gap_d   = '0;
        end
      end
      ARMED: begin
        if (clr) begin
          state_d = IDLE;
          count_d = '0;
          gap_d   = '0;
        end else if (accept && (count_q == LAST_CNT)) begin
          state_d = IDLE;
          count_d = '0;
          gap_d   = '0;
          done_d  = 1'b1;
          total_d = total_q + 16'd1;
        end else if (accept) begin
          count_d = count_q + CNT_W'(1);
          gap_d   = '0;
        end else if (GAP_ON && (gap_q == GAP_LIMIT)) begin
          // A rise on this edge would have taken the branch above, so expiry only wins alone.
          state_d   = IDLE;
          count_d   = '0;
          gap_d     = '0;
          timeout_d = 1'b1;
        end else if (gap_q != GAP_SAT) begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
        gap_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q   <= 1'b0;
      state_q   <= IDLE;
      count_q   <= '0;
      gap_q     <= '0;
      rise_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      total_q   <= '0;
    end else begin
      start_q   <= start;
      state_q   <= state_d;
      count_q   <= count_d;
      gap_q     <= gap_d;
      rise_q    <= rise;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      total_q   <= total_d;
    end
  end

  assign rise_pulse = rise_q;
  assign count      = count_q;
  assign busy       = (state_q == ARMED);
  assign done       = done_q;
  assign timeout    = timeout_q;
  assign seq_total  = total_q;

endmodule

// File: tb/tb_rise_seq_detector.sv
// Self-checking bench for rise_seq_detector: directed phases plus randomized start/en/clr/reset,
// compared each cycle against a behavioural model based on elapsed cycles and rise counts.
module tb_rise_seq_detector;

  localparam int NUM    = 3;
  localparam int GAPLIM = 4;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        clr;
  logic        start;
  logic        rise_pulse;
  logic [7:0]  count;
  logic        busy;
  logic        done;
  logic        timeout;
  logic [15:0] seq_total;

  int n_total;
  int n_bad;

  // Reference model state
  bit m_prev;
  bit m_armed;
  int m_n;
  int m_since;
  bit m_rise;
  bit m_done;
  bit m_to;
  int m_total;

  rise_seq_detector #(
    .NUM_RISES(NUM),
    .CNT_W    (8),
    .MAX_GAP  (GAPLIM),
    .GAP_W    (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .clr       (clr),
    .start     (start),
    .rise_pulse(rise_pulse),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .timeout   (timeout),
    .seq_total (seq_total)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prev  = 0;
    m_armed = 0;
    m_n     = 0;
    m_since = 0;
    m_rise  = 0;
    m_done  = 0;
    m_to    = 0;
    m_total = 0;
  endtask

  // One clock edge of the reference behaviour, using the inputs present at the edge.
  task automatic model_edge();
    bit r;
    bit acc;
    if (!rst_n) begin
      model_reset();
      return;
    end
    r      = start && !m_prev;
    m_prev = start;
    m_rise = r;
    acc    = r && en && !clr;
    m_done = 0;
    m_to   = 0;
    if (!m_armed) begin
      if (acc) begin
        m_armed = 1;
        m_n     = 1;
        m_since = 0;
      end
    end else if (clr) begin
      m_armed = 0;
      m_n     = 0;
    end else if (acc) begin
      if (m_n + 1 == NUM) begin
        m_done  = 1;
        m_total = (m_total + 1) % 65536;
        m_n     = 0;
        m_armed = 0;
      end else begin
        m_n++;
        m_since = 0;
      end
    end else begin
      m_since++;
      if (GAPLIM != 0 && m_since == GAPLIM) begin
        m_to    = 1;
        m_n     = 0;
        m_armed = 0;
      end
    end
  endtask

  task automatic compare_all();
    check("rise_pulse", int'(rise_pulse), int'(m_rise));
    check("count", int'(count), m_n);
    check("busy", int'(busy), int'(m_armed));
    check("done", int'(done), int'(m_done));
    check("timeout", int'(timeout), int'(m_to));
    check("seq_total", int'(seq_total), m_total);
  endtask

  // Called at a negedge; leaves the bench at the next negedge with outputs checked.
  task automatic step(input logic s, input logic e, input logic c);
    start = s;
    en    = e;
    clr   = c;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  // Asserts reset between edges and checks the outputs clear without waiting for a clock.
  task automatic async_reset(input int hold);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    for (int i = 0; i < hold; i++) step(start, en, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    model_reset();
    rst_n = 1'b0;
    en    = 1'b1;
    clr   = 1'b0;
    start = 1'b1;
    #1;
    compare_all();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Rises every 4 cycles: coincides with the gap limit, so no timeouts and done every 3rd rise
    for (int cyc = 0; cyc < 36; cyc++) step(logic'((cyc % 4) < 2), 1'b1, 1'b0);
    check("seq_total_after_9", int'(seq_total), 3);

    // Build count=2 then reset mid-cycle with start held high through release
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("count_before_reset", int'(count), 2);
    start = 1'b1;
    async_reset(2);
    check("count_in_reset", int'(count), 0);
    step(1'b1, 1'b1, 1'b0);
    check("count_first_edge", int'(count), 1);

    // Rises spaced 10 cycles apart: every sequence times out
    for (int cyc = 0; cyc < 40; cyc++) step(logic'((cyc % 10) < 2), 1'b1, 1'b0);
    check("seq_total_no_timeout_done", int'(seq_total), 0);

    // Two rises, clr, then three rises
    for (int cyc = 0; cyc < 8; cyc++) step(logic'((cyc % 4) < 2), 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    for (int cyc = 0; cyc < 12; cyc++) step(logic'((cyc % 4) < 2), 1'b1, 1'b0);
    check("seq_total_after_clr", int'(seq_total), 1);

    // Randomized stimulus with occasional disable, abort and asynchronous reset
    for (int cyc = 0; cyc < 4000; cyc++) begin
      logic s;
      s = ($urandom_range(0, 2) == 0) ? ~start : start;
      step(s, logic'($urandom_range(0, 7) != 0), logic'($urandom_range(0, 19) == 0));
      if ($urandom_range(0, 249) == 0) async_reset($urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/rise_seq_detector.md
Name: rise_seq_detector

Overview:
- Synthesizable stage that consumes the free-running `start` strobe and detects its rising edges.
- It counts consecutive rises and reports completion of an N-rise sequence, giving RTL the same "rise, then rise, then rise" semantics that the sequence-counting assertions check.
- It sits directly downstream of the `start` generator; its `done`/`timeout` pulses feed control logic and act as cross-check targets for the assertion bench.

Parameters:
- NUM_RISES, 3: rises required to complete a sequence; legal range 2..255.
- CNT_W, 8: width of `count`; must hold NUM_RISES.
- MAX_GAP, 16: maximum clock cycles allowed between consecutive rises while armed; 0 disables the timeout.
- GAP_W, 8: width of the gap counter; must hold MAX_GAP.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  detection enable; when 0, rises are ignored but the start history still updates.
- clr  in  1  synchronous abort: returns to IDLE and clears count.
- start  in  1  strobe, synchronous to clk.
- rise_pulse  out  1  one-cycle registered pulse per detected rise (independent of en).
- count  out  CNT_W  rises accepted in the current sequence.
- busy  out  1  high in ARMED.
- done  out  1  one-cycle pulse when the NUM_RISES-th rise is accepted.
- timeout  out  1  one-cycle pulse when the gap limit expires.
- seq_total  out  16  completed sequences since reset; wraps 0xFFFF->0.

Behaviour:
- Reset (async, rst_n=0): start_q=0, state=IDLE, count=0, gap=0, and rise_pulse=busy=done=timeout=0, seq_total=0. Release is sampled at the next posedge.
- Rise detection at edge k: rise = start(k) & ~start_q, then start_q <= start(k). This matches $rose semantics.
  - start already high at the first edge after reset counts as a rise, because start_q=0.
- rise_pulse <= rise at every edge, whatever the state or en. Accepted rise = rise & en & ~clr.
- FSM states: IDLE, ARMED. done and timeout are registered pulses; each is 0 on every cycle it is not explicitly set.
- IDLE:
  - On an accepted rise: count<=1, gap<=0, go to ARMED.
  - Otherwise hold, count=0.
- ARMED, evaluated in priority order:
  1. clr: go to IDLE, count<=0, gap<=0. No done, no timeout.
  2. Accepted rise with count==NUM_RISES-1: done<=1, seq_total<=seq_total+1, count<=0, go to IDLE.
  3. Accepted rise otherwise: count<=count+1, gap<=0.
  4. MAX_GAP!=0 and gap==MAX_GAP-1, with no accepted rise: timeout<=1, count<=0, go to IDLE.
  5. Otherwise gap<=gap+1 (saturating).
- Rise versus timeout on the same edge: the rise wins and is counted. Gap is measured in cycles after the edge of the last accepted rise.
- Back-to-back sequences: the rise that completes a sequence is not reused. The next sequence starts at the next rise after done.
- en=0 while ARMED: rises are ignored and the gap keeps counting, so timeout can still fire.
- clr in IDLE: no effect beyond keeping count=0.
- Latency: done, count and busy update on the same edge that samples the completing or counting rise, so they are visible one cycle after start goes high.
- Reset mid-sequence: everything clears immediately, with no done and no timeout.
- busy = (state==ARMED), registered.

Test Plan:
- Default params; clk period 10; start toggles every 20 (rises sampled every 4 cycles); en=1 -> rise_pulse every 4 cycles; count 1,2,0 pattern; done pulses on rises 3, 6, 9, …; seq_total=3 after 9 rises; timeout never asserted.
- MAX_GAP=3; a single rise, then start held low for 10 cycles -> busy high for 3 cycles, count=1, then timeout=1 for one cycle, count=0, IDLE; no done.
- MAX_GAP=4; rise spacing exactly 4 cycles -> rise and expiry coincide; the rise is counted, no timeout, and done fires on the 3rd rise.
- Two rises, then clr=1 for one cycle, then three rises -> count 1,2,0 after clr; done fires only on the 3rd rise after clr; seq_total=1.
- en=0 during the 2nd rise of a sequence -> rise_pulse still high, count stays 1; the next two enabled rises give count 2 then done.
- rst_n driven low asynchronously mid-cycle with count=2 -> all outputs 0 immediately; start held high through release -> the first edge counts a rise, count=1.
